// File: rtl/fft_peak_analyzer.sv
// fft_peak_analyzer: finds the strongest bin of each 16-point FFT frame.
// Scans LANES bins per cycle; a one-frame pending buffer absorbs arrivals.
module fft_peak_analyzer #(
    parameter int LANES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fft_valid,
    input  logic [31:0] fft_d0,
    input  logic [31:0] fft_d1,
    input  logic [31:0] fft_d2,
    input  logic [31:0] fft_d3,
    input  logic [31:0] fft_d4,
    input  logic [31:0] fft_d5,
    input  logic [31:0] fft_d6,
    input  logic [31:0] fft_d7,
    input  logic [31:0] fft_d8,
    input  logic [31:0] fft_d9,
    input  logic [31:0] fft_d10,
    input  logic [31:0] fft_d11,
    input  logic [31:0] fft_d12,
    input  logic [31:0] fft_d13,
    input  logic [31:0] fft_d14,
    input  logic [31:0] fft_d15,
    output logic        done,
    output logic [3:0]  freq,
    output logic [31:0] peak_mag,
    output logic        busy,
    output logic        overrun
);

    localparam int S = 16 / LANES;
    localparam logic [3:0] LAST = 4'(S - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t      state_q, state_d;
    logic [31:0] din [16];
    logic [31:0] act_q [16];
    logic [31:0] act_d [16];
    logic [31:0] pend_q [16];
    logic [31:0] pend_d [16];
    logic        pv_q, pv_d;
    logic [3:0]  grp_q, grp_d;
    logic [31:0] best_q, best_d;
    logic [3:0]  bidx_q, bidx_d;
    logic        done_q, done_d;
    logic [3:0]  freq_q, freq_d;
    logic [31:0] mag_q, mag_d;
    logic        ovr_q, ovr_d;

    logic [31:0]        cbest;
    logic [3:0]         cidx;
    logic [3:0]         kidx;
    logic [31:0]        word;
    logic signed [15:0] re, im;
    logic signed [31:0] re2, im2;
    logic [31:0]        mag;

    assign din[0]  = fft_d0;
    assign din[1]  = fft_d1;
    assign din[2]  = fft_d2;
    assign din[3]  = fft_d3;
    assign din[4]  = fft_d4;
    assign din[5]  = fft_d5;
    assign din[6]  = fft_d6;
    assign din[7]  = fft_d7;
    assign din[8]  = fft_d8;
    assign din[9]  = fft_d9;
    assign din[10] = fft_d10;
    assign din[11] = fft_d11;
    assign din[12] = fft_d12;
    assign din[13] = fft_d13;
    assign din[14] = fft_d14;
    assign din[15] = fft_d15;

    assign done     = done_q;
    assign freq     = freq_q;
    assign peak_mag = mag_q;
    assign overrun  = ovr_q;
    assign busy     = (state_q == SCAN) | pv_q;

    // Running maximum over this cycle's group, ascending so ties keep the lower bin
    always_comb begin
        cbest = best_q;
        cidx  = bidx_q;
        kidx  = '0;
        word  = '0;
        re    = '0;
        im    = '0;
        re2   = '0;
        im2   = '0;
        mag   = '0;
        for (int l = 0; l < LANES; l++) begin
            kidx = 4'(int'(grp_q) * LANES + l);
            word = act_q[kidx];
            re   = signed'(word[31:16]);
            im   = signed'(word[15:0]);
            re2  = re * re;
            im2  = im * im;
            mag  = unsigned'(re2) + unsigned'(im2);
            if (mag > cbest) begin
                cbest = mag;
                cidx  = kidx;
            end
        end
    end

    // Next-state: frame capture, scan stepping, pending hand-off, result update
    always_comb begin
        state_d = state_q;
        act_d   = act_q;
        pend_d  = pend_q;
        pv_d    = pv_q;
        grp_d   = grp_q;
        best_d  = best_q;
        bidx_d  = bidx_q;
        done_d  = 1'b0;
        freq_d  = freq_q;
        mag_d   = mag_q;
        ovr_d   = ovr_q;
        unique case (state_q)
            IDLE: begin
                if (fft_valid) begin
                    act_d   = din;
                    grp_d   = '0;
                    best_d  = '0;
                    bidx_d  = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                best_d = cbest;
                bidx_d = cidx;
                grp_d  = grp_q + 4'd1;
                if (grp_q == LAST) begin
                    freq_d = cidx;
                    mag_d  = cbest;
                    done_d = 1'b1;
                    best_d = '0;
                    bidx_d = '0;
                    grp_d  = '0;
                    if (pv_q) begin
                        act_d = pend_q;
                        pv_d  = fft_valid;
                        if (fft_valid) begin
                            pend_d = din;
                        end
                    end else if (fft_valid) begin
                        act_d = din;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (fft_valid) begin
                    if (!pv_q) begin
                        pend_d = din;
                        pv_d   = 1'b1;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and data registers; frame buffers need no reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pv_q    <= 1'b0;
            grp_q   <= '0;
            best_q  <= '0;
            bidx_q  <= '0;
            done_q  <= 1'b0;
            freq_q  <= '0;
            mag_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            pv_q    <= pv_d;
            grp_q   <= grp_d;
            best_q  <= best_d;
            bidx_q  <= bidx_d;
            done_q  <= done_d;
            freq_q  <= freq_d;
            mag_q   <= mag_d;
            ovr_q   <= ovr_d;
        end
    end

endmodule

// File: tb/tb_fft_peak_analyzer.sv
// tb_fft_peak_analyzer: directed checks of peak search, latency,
// back-to-back flow, overrun and mid-scan reset for LANES = 1, 2, 4.
module tb_fft_peak_analyzer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fft_valid = 1'b0;
    logic [31:0] d [16];
    logic        done_w [3];
    logic [3:0]  freq_w [3];
    logic [31:0] mag_w [3];
    logic        busy_w [3];
    logic        ovr_w [3];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;

    // Free-running clock and edge counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        fft_peak_analyzer #(.LANES(1 << g)) u_dut (
            .clk(clk), .rst(rst), .fft_valid(fft_valid),
            .fft_d0(d[0]), .fft_d1(d[1]), .fft_d2(d[2]), .fft_d3(d[3]),
            .fft_d4(d[4]), .fft_d5(d[5]), .fft_d6(d[6]), .fft_d7(d[7]),
            .fft_d8(d[8]), .fft_d9(d[9]), .fft_d10(d[10]), .fft_d11(d[11]),
            .fft_d12(d[12]), .fft_d13(d[13]), .fft_d14(d[14]), .fft_d15(d[15]),
            .done(done_w[g]), .freq(freq_w[g]), .peak_mag(mag_w[g]),
            .busy(busy_w[g]), .overrun(ovr_w[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input int k, input logic [31:0] v);
        for (int i = 0; i < 16; i++) d[i] = '0;
        d[k] = v;
    endtask

    // One frame into all three widths; latency is 16/LANES cycles
    task automatic run_frame(input string tag, input logic [3:0] ef,
                             input logic [31:0] em);
        int          c0;
        int          lat [3];
        int          cnt [3];
        logic [3:0]  f [3];
        logic [31:0] m [3];
        for (int i = 0; i < 3; i++) begin
            lat[i] = -1;
            cnt[i] = 0;
            f[i]   = 'x;
            m[i]   = 'x;
        end
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
        c0 = cyc;
        repeat (24) begin
            tick();
            for (int i = 0; i < 3; i++) begin
                if (done_w[i]) begin
                    cnt[i]++;
                    if (lat[i] < 0) lat[i] = cyc - c0;
                    f[i] = freq_w[i];
                    m[i] = mag_w[i];
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s L%0d lat", tag, 1 << i), 32'(lat[i]), 32'(16 >> i));
            check($sformatf("%s L%0d pulses", tag, 1 << i), 32'(cnt[i]), 32'd1);
            check($sformatf("%s L%0d freq", tag, 1 << i), 32'(f[i]), 32'(ef));
            check($sformatf("%s L%0d mag", tag, 1 << i), m[i], em);
        end
    endtask

    initial begin
        int          c0;
        int          n;
        int          dc [8];
        logic [3:0]  df [8];

        load(0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
        check("rst done", 32'(done_w[1]), 32'd0);
        check("rst freq", 32'(freq_w[1]), 32'd0);
        check("rst mag", mag_w[1], 32'd0);
        check("rst busy", 32'(busy_w[1]), 32'd0);
        check("rst ovr", 32'(ovr_w[1]), 32'd0);

        do_reset();
        load(1, 32'h0100_0000);
        run_frame("single", 4'd1, 32'h0001_0000);

        do_reset();
        load(15, 32'hFE00_0300);
        d[4] = 32'h0300_0100;
        run_frame("neg", 4'd15, 32'h000D_0000);

        // bin4 (3,2) and bin15 (-2,3) both give 13.0: lower index wins
        do_reset();
        load(15, 32'hFE00_0300);
        d[4] = 32'h0300_0200;
        run_frame("negtie", 4'd4, 32'h000D_0000);

        do_reset();
        load(3, 32'h0200_0000);
        d[9] = 32'h0200_0000;
        run_frame("tie", 4'd3, 32'h0004_0000);

        do_reset();
        load(0, 32'h0);
        run_frame("zero", 4'd0, 32'h0);

        // Back-to-back every 8 cycles, peaks 1,15,1,15
        do_reset();
        n = 0;
        c0 = 0;
        for (int t = 0; t < 40; t++) begin
            if (t % 8 == 0 && t < 32) begin
                load(((t / 8) % 2 == 0) ? 1 : 15, 32'h0100_0000);
                fft_valid = 1'b1;
            end
            tick();
            fft_valid = 1'b0;
            if (t == 0) c0 = cyc;
            if (done_w[1] && n < 8) begin
                dc[n] = cyc - c0;
                df[n] = freq_w[1];
                n++;
            end
        end
        check("b2b pulses", 32'(n), 32'd4);
        for (int i = 0; i < 4 && i < n; i++) begin
            check($sformatf("b2b t%0d", i), 32'(dc[i]), 32'(8 * (i + 1)));
            check($sformatf("b2b f%0d", i), 32'(df[i]), (i % 2 == 0) ? 32'd1 : 32'd15);
        end
        check("b2b ovr", 32'(ovr_w[1]), 32'd0);

        // Frames at N, N+2, N+4: the third is dropped
        do_reset();
        n = 0;
        for (int t = 0; t < 24; t++) begin
            if (t == 0) load(2, 32'h0100_0000);
            if (t == 2) load(5, 32'h0100_0000);
            if (t == 4) load(7, 32'h0100_0000);
            fft_valid = (t == 0 || t == 2 || t == 4);
            tick();
            fft_valid = 1'b0;
            if (t == 0) c0 = cyc;
            if (done_w[1] && n < 8) begin
                dc[n] = cyc - c0;
                df[n] = freq_w[1];
                n++;
            end
        end
        check("ovr pulses", 32'(n), 32'd2);
        if (n >= 2) begin
            check("ovr t0", 32'(dc[0]), 32'd8);
            check("ovr f0", 32'(df[0]), 32'd2);
            check("ovr t1", 32'(dc[1]), 32'd16);
            check("ovr f1", 32'(df[1]), 32'd5);
        end
        check("ovr flag", 32'(ovr_w[1]), 32'd1);
        check("ovr idle", 32'(busy_w[1]), 32'd0);

        // Reset at N+3 abandons frame N; frame at N+5 completes at N+13
        n = 0;
        for (int t = 0; t < 24; t++) begin
            if (t == 0) load(6, 32'h0100_0000);
            if (t == 5) load(9, 32'h0100_0000);
            fft_valid = (t == 0 || t == 5);
            rst = (t == 3);
            tick();
            fft_valid = 1'b0;
            rst = 1'b0;
            if (t == 0) c0 = cyc;
            if (t == 3) begin
                check("mid done", 32'(done_w[1]), 32'd0);
                check("mid freq", 32'(freq_w[1]), 32'd0);
                check("mid mag", mag_w[1], 32'd0);
                check("mid busy", 32'(busy_w[1]), 32'd0);
                check("mid ovr", 32'(ovr_w[1]), 32'd0);
            end
            if (done_w[1] && n < 8) begin
                dc[n] = cyc - c0;
                df[n] = freq_w[1];
                n++;
            end
        end
        check("mid pulses", 32'(n), 32'd1);
        if (n >= 1) begin
            check("mid t", 32'(dc[0]), 32'd13);
            check("mid f", 32'(df[0]), 32'd9);
        end
        check("mid hold", 32'(freq_w[1]), 32'd9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
